// File: rtl/riscv_pkg.sv
// Shared RISC-V control-flow constants, FSM state type and BHT counter update helper.
package riscv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } brs_state_t;

  localparam logic [1:0] BHT_RESET = 2'b01;

  // Saturating 2-bit counter step: taken counts up to 11, not-taken down to 00.
  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case ({taken, ctr})
      3'b1_00: nxt = 2'b01;
      3'b1_01: nxt = 2'b10;
      3'b1_10: nxt = 2'b11;
      3'b1_11: nxt = 2'b11;
      3'b0_00: nxt = 2'b00;
      3'b0_01: nxt = 2'b00;
      3'b0_10: nxt = 2'b01;
      3'b0_11: nxt = 2'b10;
      default: nxt = BHT_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// 2-bit saturating branch history table: async read for fetch, sync counter update at resolve.
module branch_history_table
  import riscv_pkg::*;
#(
  parameter int BHT_ENTRIES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx_i,
  output logic [1:0]                     rd_ctr_o,
  input  logic                           we_i,
  input  logic [$clog2(BHT_ENTRIES)-1:0] wr_idx_i,
  input  logic                           wr_taken_i
);

  logic [1:0] ctr_q [BHT_ENTRIES];

  // Counter array: reset to weakly-not-taken, one entry updated per accepted branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else if (we_i) begin
      ctr_q[wr_idx_i] <= bht_next(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

  // Read is purely combinational, so a same-cycle write is seen only next cycle.
  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution: condition evaluation, target calc, mispredict flush FSM.
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_taken_o,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            pred_taken_i,
  output logic            res_valid_o,
  output logic            taken_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            illegal_o,
  output logic            flush_o
);

  localparam int IDXW = $clog2(BHT_ENTRIES);
  localparam int CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  brs_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic            res_valid_q, taken_q, mispredict_q, illegal_q;
  logic [XLEN-1:0] redirect_q;

  logic            accept;
  logic            taken_d, mispredict_d, illegal_d, bht_we;
  logic [XLEN-1:0] redirect_d;
  logic [XLEN-1:0] br_target, fall_thru, jalr_sum;
  logic [1:0]      rd_ctr;
  logic            unused_fetch_bits;

  assign accept    = valid_i & ~stall_i & (state_q == IDLE);
  assign br_target = pc_i + imm_i;
  assign fall_thru = pc_i + XLEN'(3'd4);
  assign jalr_sum  = rs1_i + imm_i;

  // Resolve outcome, prediction check and correct next PC for the presented instruction.
  always_comb begin
    taken_d      = 1'b0;
    mispredict_d = 1'b0;
    illegal_d    = 1'b0;
    redirect_d   = fall_thru;
    case (opcode_i)
      OPC_BRANCH: begin
        case (funct3_i)
          F3_BEQ:  taken_d = (rs1_i == rs2_i);
          F3_BNE:  taken_d = (rs1_i != rs2_i);
          F3_BLT:  taken_d = ($signed(rs1_i) <  $signed(rs2_i));
          F3_BGE:  taken_d = ($signed(rs1_i) >= $signed(rs2_i));
          F3_BLTU: taken_d = (rs1_i <  rs2_i);
          F3_BGEU: taken_d = (rs1_i >= rs2_i);
          default: illegal_d = 1'b1;
        endcase
        if (!illegal_d) begin
          mispredict_d = taken_d ^ pred_taken_i;
          redirect_d   = taken_d ? br_target : fall_thru;
        end else begin
          mispredict_d = 1'b0;
          redirect_d   = fall_thru;
        end
      end
      OPC_JAL: begin
        taken_d      = 1'b1;
        mispredict_d = 1'b1;
        redirect_d   = br_target;
      end
      OPC_JALR: begin
        taken_d      = 1'b1;
        mispredict_d = 1'b1;
        redirect_d   = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: begin
        taken_d      = 1'b0;
        mispredict_d = 1'b0;
        redirect_d   = fall_thru;
      end
    endcase
  end

  assign bht_we = accept & (opcode_i == OPC_BRANCH) & ~illegal_d;

  // Flush FSM next state: a mispredict opens a FLUSH window that counts down ignoring stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && mispredict_d) begin
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Flush FSM state and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result registers: pulse valid on acceptance, hold the last result otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= '0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        taken_q      <= taken_d;
        mispredict_q <= mispredict_d;
        illegal_q    <= illegal_d;
        redirect_q   <= redirect_d;
      end
    end
  end

  branch_history_table #(
    .BHT_ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (fetch_pc_i[IDXW+1:2]),
    .rd_ctr_o   (rd_ctr),
    .we_i       (bht_we),
    .wr_idx_i   (pc_i[IDXW+1:2]),
    .wr_taken_i (taken_d)
  );

  // Only the word-index bits of the fetch PC select a BHT entry.
  assign unused_fetch_bits = ^{fetch_pc_i[XLEN-1:IDXW+2], fetch_pc_i[1:0]};

  assign pred_taken_o  = rd_ctr[1];
  assign res_valid_o   = res_valid_q;
  assign taken_o       = taken_q;
  assign mispredict_o  = mispredict_q;
  assign illegal_o     = illegal_q;
  assign redirect_pc_o = redirect_q;
  assign flush_o       = (state_q == FLUSH);

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, registered branch/jump resolution unit for the RISC-V pipeline. It evaluates all six RV32I branch conditions with true signed and unsigned compares, and computes JAL/JALR targets. It compares each outcome with the fetch-stage prediction, drives a multi-cycle flush/redirect on mispredict, and owns the 2-bit saturating branch history table (BHT) the front end reads for predictions.

## Interface
Parameters:
- XLEN, 32, operand/PC width
- BHT_ENTRIES, 16, BHT depth; power of 2, ≥2
- FLUSH_CYCLES, 2, cycles flush_o stays high per redirect; ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_pc_i  in  XLEN  PC being fetched (BHT lookup)
- pred_taken_o  out  1  combinational BHT prediction for fetch_pc_i
- valid_i  in  1  control-flow candidate present
- stall_i  in  1  pipeline stall
- opcode_i  in  7  instruction opcode
- funct3_i  in  3  instruction funct3
- pc_i  in  XLEN  instruction PC
- imm_i  in  XLEN  sign-extended immediate
- rs1_i, rs2_i  in  XLEN  operands
- pred_taken_i  in  1  prediction carried from fetch
- res_valid_o  out  1  registered result valid (1-cycle pulse)
- taken_o  out  1  resolved taken
- mispredict_o  out  1  redirect required
- redirect_pc_o  out  XLEN  correct next PC
- illegal_o  out  1  branch opcode with funct3 010/011
- flush_o  out  1  kill younger stages

## Operation
- Accepted instruction: valid_i & ~stall_i, state IDLE.
- Opcode 1100011 (branch), selected by funct3:
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed <
  - 101 BGE: signed ≥
  - 110 BLTU: unsigned <
  - 111 BGEU: unsigned ≥
  - 010/011: not taken, illegal_o=1, no BHT update, no redirect
- Branch target = pc_i+imm_i; fall-through = pc_i+4. All sums are modulo 2^XLEN (wrap, no overflow flag).
- Branch: mispredict = taken ^ pred_taken_i. redirect_pc_o = taken ? target : pc+4.
- JAL (1101111): taken, target pc+imm. JALR (1100111): taken, target (rs1+imm)&~1. Jumps always set mispredict (no BTB).
- Other opcodes: res_valid_o=1, taken_o=0, mispredict_o=0.
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1:2].
  - 2-bit counters, reset value 01. MSB is the prediction.
  - Updated only on a legal accepted branch: taken → saturating increment (max 11); not taken → saturating decrement (min 00).
- FSM:
  - IDLE → FLUSH on an accepted mispredict. Counter loads FLUSH_CYCLES-1.
  - FLUSH: flush_o=1. valid_i is ignored (no result, no BHT update). Counter decrements every cycle regardless of stall_i. At 0, return to IDLE.
- stall_i in IDLE: nothing accepted; res_valid_o=0; outputs other than res_valid_o hold their values.

## Timing
- Latency: one cycle. Inputs accepted at edge t produce res_valid_o/taken_o/mispredict_o/redirect_pc_o/illegal_o valid after edge t. flush_o is high for exactly FLUSH_CYCLES cycles starting then.
- BHT lookup is combinational. A same-cycle read of an entry being written returns the old value; the new value is visible the next cycle.
- Reset (asynchronous, any time, including mid-FLUSH):
  - All outputs 0 and redirect_pc_o = 0 immediately.
  - FSM = IDLE, counter = 0, all BHT entries = 01.
  - First acceptance occurs at the first edge after rst_n deasserts.
- Back-to-back accepted correctly-predicted branches: one result per cycle, no bubbles.

## Structure
- Shared package riscv_pkg holds:
  - OPC_BRANCH / OPC_JAL / OPC_JALR
  - F3_BEQ…F3_BGEU
  - brs_state_t {IDLE, FLUSH}
  - BHT_RESET = 2'b01
- Sub-module branch_history_table: parameter BHT_ENTRIES; one async read port, one sync write port with increment/decrement update, and async reset.
- Compare/target logic and the FSM live in branch_resolve_unit.

## Test plan
- BLT vs BLTU, rs1=0xFFFF_FFFF, rs2=1, pred 0 → BLT: taken=1, mispredict=1, redirect=pc+imm. BLTU: taken=0, mispredict=0.
- BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred 0 → one cycle later mispredict=1, redirect=0x120, flush_o high 2 cycles. valid_i during flush produces no res_valid_o.
- JALR rs1=0x1003, imm=0 → taken=1, redirect=0x1002, mispredict=1.
- Same branch at pc=0x40 resolved taken ×3 → BHT[0] goes 01→10→11→11; pred_taken_o for fetch_pc=0x40 is 1 after the first update. Then not taken ×3 → 10→01→00.
- funct3=010 with opcode 1100011 → illegal_o=1, taken=0, no flush, BHT unchanged.
- rst_n low during cycle 1 of FLUSH → flush_o=0 immediately, all BHT entries 01, a BEQ accepted after release resolves normally.
